// File: rtl/atm_txn_logger.sv
// atm_txn_logger
// Turns each completed or failed ATM operation into one log record, buffers the
// records in a first-word-fall-through FIFO with a registered head, and keeps
// saturating statistics for dropped records and wrong-password attempts.

module atm_txn_logger #(
    parameter int card_width    = 3,
    parameter int balance_width = 20,
    parameter int depth         = 8,
    parameter int cnt_width     = 8
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [card_width-1:0]                           card_number,
    input  logic [1:0]                                      operation,
    input  logic [balance_width-1:0]                        updated_balance,
    input  logic                                            op_done,
    input  logic                                            error,
    input  logic                                            wrong_psw,
    input  logic                                            clear_stats,
    input  logic                                            log_ready,
    output logic                                            log_valid,
    output logic [cnt_width+card_width+3+balance_width-1:0] log_data,
    output logic [$clog2(depth):0]                          fifo_count,
    output logic [cnt_width-1:0]                            overflow_cnt,
    output logic [cnt_width-1:0]                            wrong_psw_cnt
);

    localparam int REC_W = cnt_width + card_width + 3 + balance_width;
    localparam int PTR_W = $clog2(depth);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(depth);
    localparam logic [CNT_W-1:0]     ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [cnt_width-1:0] SAT_C   = {cnt_width{1'b1}};
    localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

    logic [REC_W-1:0]     mem_r [depth];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic [REC_W-1:0]     log_data_r;
    logic                 log_valid_r;
    logic [cnt_width-1:0] seq_r;
    logic [cnt_width-1:0] overflow_cnt_r;
    logic [cnt_width-1:0] wrong_psw_cnt_r;
    logic                 evt_q_r;
    logic                 psw_q_r;

    logic                 evt_s;
    logic                 push_req_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 accept_s;
    logic                 drop_s;
    logic                 psw_rise_s;
    logic [REC_W-1:0]     record_s;
    logic [PTR_W-1:0]     rd_ptr_nxt_s;
    logic [CNT_W-1:0]     remain_s;
    logic [CNT_W-1:0]     count_nxt_s;
    logic [REC_W-1:0]     head_nxt_s;

    assign log_valid     = log_valid_r;
    assign log_data      = log_data_r;
    assign fifo_count    = count_r;
    assign overflow_cnt  = overflow_cnt_r;
    assign wrong_psw_cnt = wrong_psw_cnt_r;

    // Event edge detection, push/pop arbitration and next-head selection.
    always_comb begin
        evt_s        = op_done | error;
        push_req_s   = evt_s & ~evt_q_r;
        psw_rise_s   = wrong_psw & ~psw_q_r;
        pop_s        = (count_r != {CNT_W{1'b0}}) & log_ready;
        full_s       = (count_r == DEPTH_C);
        // A full FIFO still takes a record when the head leaves on the same edge.
        accept_s     = push_req_s & (~full_s | pop_s);
        drop_s       = push_req_s & ~accept_s;
        record_s     = {seq_r, card_number, operation, error, updated_balance};
        rd_ptr_nxt_s = rd_ptr_r;
        remain_s     = count_r;
        count_nxt_s  = count_r;
        head_nxt_s   = log_data_r;

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            remain_s     = count_r - ONE_C;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
            remain_s     = count_r;
        end

        case ({accept_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase

        // With nothing left behind the head, the incoming record bypasses
        // storage; with nothing at all, the last value is simply kept.
        if (remain_s == {CNT_W{1'b0}}) begin
            if (accept_s) begin
                head_nxt_s = record_s;
            end else begin
                head_nxt_s = log_data_r;
            end
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers, occupancy, registered head and sequence number.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_r[i] <= {REC_W{1'b0}};
            end
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            log_data_r  <= {REC_W{1'b0}};
            log_valid_r <= 1'b0;
            seq_r       <= {cnt_width{1'b0}};
            evt_q_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                mem_r[wr_ptr_r] <= record_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            // Dropped records still consume a sequence number so gaps show drops.
            if (push_req_s) begin
                seq_r <= seq_r + CNT_ONE;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            log_data_r  <= head_nxt_s;
            log_valid_r <= (count_nxt_s != {CNT_W{1'b0}});
            evt_q_r     <= evt_s;
        end
    end

    // Saturating statistics counters; a clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_cnt_r  <= {cnt_width{1'b0}};
            wrong_psw_cnt_r <= {cnt_width{1'b0}};
            psw_q_r         <= 1'b0;
        end else begin
            psw_q_r <= wrong_psw;
            if (clear_stats) begin
                overflow_cnt_r  <= {cnt_width{1'b0}};
                wrong_psw_cnt_r <= {cnt_width{1'b0}};
            end else begin
                if (drop_s && (overflow_cnt_r != SAT_C)) begin
                    overflow_cnt_r <= overflow_cnt_r + CNT_ONE;
                end
                if (psw_rise_s && (wrong_psw_cnt_r != SAT_C)) begin
                    wrong_psw_cnt_r <= wrong_psw_cnt_r + CNT_ONE;
                end
            end
        end
    end

endmodule
